// File: rtl/arb10_rr_coder_if.sv
// Request/grant bundle for the 10-way round-robin arbiter.
// Handshake: i_req[k] is a level request, held by requester k for as long
// as it wants service; o_grant/o_code change only on i_clk rising edges and
// a grant is released by an i_done pulse, by dropping i_req[k], or by the
// hold limit, whichever is sampled first.
interface arb10_rr_coder_if;
    logic [9:0] i_req;
    logic       i_done;
    logic [9:0] o_grant;
    logic [3:0] o_code;
    logic       o_busy;
    logic [1:0] o_state;

    modport master (
        output i_req,
        output i_done,
        input  o_grant,
        input  o_code,
        input  o_busy,
        input  o_state
    );

    modport slave (
        input  i_req,
        input  i_done,
        output o_grant,
        output o_code,
        output o_busy,
        output o_state
    );
endinterface

// File: rtl/arb10_rr_coder.sv
// 10-requester round-robin arbiter with bounded hold time and an encoded
// grant index (k+1, zero when idle). States: IDLE -> GRANT -> GAP -> IDLE.
// All outputs are registered; o_state exposes the FSM for debug.
module arb10_rr_coder #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    arb10_rr_coder_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_ptr;
    logic [7:0] r_hold;
    logic [3:0] r_idx;
    logic [9:0] r_grant;
    logic [3:0] r_code;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [3:0] w_ptr_nxt;
    logic [7:0] w_hold_nxt;
    logic [3:0] w_idx_nxt;
    logic [9:0] w_grant_nxt;
    logic [3:0] w_code_nxt;
    logic       w_busy_nxt;

    logic [19:0] w_dbl;
    logic [9:0]  w_rot;
    logic [4:0]  w_sum;
    logic [3:0]  w_sel;
    logic        w_found;
    logic        w_release;

    // Round-robin search: rotate the request vector so ptr lands at bit 0,
    // take the lowest set bit, then map the offset back to a channel index.
    always_comb begin
        w_dbl   = {bus.i_req, bus.i_req} >> r_ptr;
        w_rot   = w_dbl[9:0];
        w_found = |w_rot;
        w_sum   = 5'd0;
        for (int i = 9; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = {1'b0, r_ptr} + 5'(i);
            end
        end
        w_sel = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];
    end

    // Next state and registered outputs; one release per grant even when
    // done, request-drop and hold-limit coincide.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = r_idx;
        w_grant_nxt = r_grant;
        w_code_nxt  = r_code;
        w_busy_nxt  = r_busy;
        w_release   = bus.i_done || ((bus.i_req & r_grant) == 10'd0) ||
                      (r_hold == 8'(MAX_HOLD));
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 10'd0;
                w_code_nxt  = 4'd0;
                w_busy_nxt  = 1'b0;
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_idx_nxt   = w_sel;
                    w_hold_nxt  = 8'd1;
                    w_grant_nxt = 10'd1 << w_sel;
                    w_code_nxt  = w_sel + 4'd1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_GRANT: begin
                w_busy_nxt = 1'b1;
                if (w_release) begin
                    w_state_nxt = ST_GAP;
                    w_grant_nxt = 10'd0;
                    w_code_nxt  = 4'd0;
                    w_ptr_nxt   = (r_idx == 4'd9) ? 4'd0 : r_idx + 4'd1;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 10'd0;
                w_code_nxt  = 4'd0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 10'd0;
                w_code_nxt  = 4'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any grant and restarts at ch0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 4'd0;
            r_hold  <= 8'd0;
            r_idx   <= 4'd0;
            r_grant <= 10'd0;
            r_code  <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_idx   <= w_idx_nxt;
            r_grant <= w_grant_nxt;
            r_code  <= w_code_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign bus.o_grant = r_grant;
    assign bus.o_code  = r_code;
    assign bus.o_busy  = r_busy;
    assign bus.o_state = r_state;

endmodule
